pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning write-data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning destination-register address width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_ready  output  1  stage accepts entry this cycle.
REQ-009 SHALL have ports in_wd, in_wreg, in_wdata  input  ADDR_W, 1, DATA_W  upstream destination, write-enable, data.
REQ-010 SHALL have port out_valid  output  1  entry presented downstream.
REQ-011 SHALL have port out_ready  input  1  downstream consumes entry.
REQ-012 SHALL have ports out_wd, out_wreg, out_wdata  output  ADDR_W, 1, DATA_W  presented destination, write-enable, data.
REQ-013 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-014 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-015 SHALL present an accepted entry on out_* one cycle after acceptance, if the stage was empty or drained that same cycle.
REQ-016 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-017 SHALL drive out_wd=0, out_wreg=0, out_wdata=0 whenever out_valid=0; writeback sees a bubble, never stale data.
REQ-018 SHALL preserve order; no entry is dropped or duplicated except by flush.
REQ-019 SHALL, on flush=1, empty the stage at the next edge (out_valid=0 following cycle), ignoring in_valid that cycle; flush has priority over every transfer.
REQ-020 SHALL deassert in_ready during a flush cycle.
REQ-021 SHALL increment stall_cnt each cycle with out_valid=1 and out_ready=0, saturating at all-ones (no wrap); flush does not clear it.
REQ-022 SHALL allow simultaneous accept and drain in one cycle with no bubble (full throughput, one entry/cycle).

Reset
REQ-023 SHALL, with rst=1 at an edge, set out_valid=0, out_wd=0, out_wreg=0, out_wdata=0, stall_cnt=0, skid entry empty.
REQ-024 SHALL hold in_ready=0 while rst=1; rst overrides flush and any in-flight transfer.
REQ-025 SHALL resume normal operation on the first edge after rst deasserts, the stage empty.

Configuration
REQ-026 SHALL, with PIPE_STAGE_SKID_EN defined, include a one-entry skid buffer: in_ready is a register (=skid empty), capacity two entries; an entry accepted while out stalled goes to skid, moving to out when out drains.
REQ-027 SHALL, with PIPE_STAGE_SKID_EN undefined, hold a single entry, in_ready = !out_valid || out_ready (combinational), capacity one.
REQ-028 SHALL exhibit identical ordering, latency, flush and reset behaviour in both configurations; only capacity and in_ready timing differ.

Verification
REQ-029 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_wreg=0, out_wd=0, out_wdata=0, stall_cnt=0, in_ready=0.
REQ-030 Streaming: in_valid=1, out_ready=1, wd=1..8, wdata=0x100+n -> outputs appear 1 cycle later, in order, one per cycle, no bubbles.
REQ-031 Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_* stable, stall_cnt=5; with skid, second entry accepted then in_ready=0; without, in_ready=0 immediately.
REQ-032 Flush: flush=1 with stage full and in_valid=1 -> next cycle out_valid=0, out_wreg=0, skid empty, flushed-cycle input absent.
REQ-033 Saturation: CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-034 Mid-operation reset: rst=1 with stage full, out_ready=0 -> next cycle all outputs at reset values, stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, bubble-zeroed outputs and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer (capacity two, in_ready depends only on held state).
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_wd_q, out_wd_d;
  logic              out_wreg_q, out_wreg_d;
  logic [DATA_W-1:0] out_wdata_q, out_wdata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept_s, drain_s;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0] skid_wd_q, skid_wd_d;
  logic              skid_wreg_q, skid_wreg_d;
  logic [DATA_W-1:0] skid_wdata_q, skid_wdata_d;
`endif

  // Ready is withheld during reset and flush so nothing is accepted in those cycles.
  always_comb begin
`ifdef PIPE_STAGE_SKID_EN
    in_ready = !skid_valid_q && !flush && !rst;
`else
    in_ready = (!out_valid_q || out_ready) && !flush && !rst;
`endif
  end

  assign accept_s = in_valid && in_ready;
  assign drain_s  = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_wd_d    = out_wd_q;
    out_wreg_d  = out_wreg_q;
    out_wdata_d = out_wdata_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_wd_d    = skid_wd_q;
    skid_wreg_d  = skid_wreg_q;
    skid_wdata_d = skid_wdata_q;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
      out_wd_d    = '0;
      out_wreg_d  = 1'b0;
      out_wdata_d = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
      skid_wd_d    = '0;
      skid_wreg_d  = 1'b0;
      skid_wdata_d = '0;
`endif
    end else if (!out_valid_q || drain_s) begin
`ifdef PIPE_STAGE_SKID_EN
      if (skid_valid_q) begin
        // Skid holds the older entry, so it moves out first.
        out_valid_d  = 1'b1;
        out_wd_d     = skid_wd_q;
        out_wreg_d   = skid_wreg_q;
        out_wdata_d  = skid_wdata_q;
        skid_valid_d = 1'b0;
        skid_wd_d    = '0;
        skid_wreg_d  = 1'b0;
        skid_wdata_d = '0;
      end else
`endif
      if (accept_s) begin
        out_valid_d = 1'b1;
        out_wd_d    = in_wd;
        out_wreg_d  = in_wreg;
        out_wdata_d = in_wdata;
      end else begin
        out_valid_d = 1'b0;
        out_wd_d    = '0;
        out_wreg_d  = 1'b0;
        out_wdata_d = '0;
      end
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      if (accept_s) begin
        skid_valid_d = 1'b1;
        skid_wd_d    = in_wd;
        skid_wreg_d  = in_wreg;
        skid_wdata_d = in_wdata;
      end else begin
        skid_valid_d = skid_valid_q;
      end
`else
      out_valid_d = out_valid_q;
`endif
    end
  end

  // Saturating stall counter; flush deliberately leaves it alone.
  always_comb begin
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_wd_q    <= '0;
      out_wreg_q  <= 1'b0;
      out_wdata_q <= '0;
      stall_cnt_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_wd_q    <= '0;
      skid_wreg_q  <= 1'b0;
      skid_wdata_q <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_wd_q    <= out_wd_d;
      out_wreg_q  <= out_wreg_d;
      out_wdata_q <= out_wdata_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_wd_q    <= skid_wd_d;
      skid_wreg_q  <= skid_wreg_d;
      skid_wdata_q <= skid_wdata_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_wd    = out_wd_q;
  assign out_wreg  = out_wreg_q;
  assign out_wdata = out_wdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready, in_wreg;
  logic              in_ready, out_valid, out_wreg;
  logic [ADDR_W-1:0] in_wd, out_wd;
  logic [DATA_W-1:0] in_wdata, out_wdata;
  logic [CNT_W-1:0]  stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue of held entries {wd, wreg, wdata}; front is what's presented.
  logic [ADDR_W+DATA_W:0] mq[$];
  int m_cnt = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One cycle: drive, check against model, clock, advance model.
  task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                      input logic [ADDR_W-1:0] wd, input logic wr, input logic [DATA_W-1:0] wdata);
    logic e_ready, e_valid;
    logic [ADDR_W+DATA_W:0] front;
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_wd = wd; in_wreg = wr; in_wdata = wdata;
    #1;
    e_valid = (mq.size() > 0);
    front   = e_valid ? mq[0] : '0;
    if (CAP == 2) e_ready = !r && !f && (mq.size() < 2);
    else          e_ready = !r && !f && (mq.size() == 0 || ordy);
    chk("in_ready",  {63'd0, in_ready},  {63'd0, e_ready});
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_valid});
    chk("out_wd",    {59'd0, out_wd},    {59'd0, front[ADDR_W+DATA_W:DATA_W+1]});
    chk("out_wreg",  {63'd0, out_wreg},  {63'd0, front[DATA_W]});
    chk("out_wdata", {32'd0, out_wdata}, {32'd0, front[DATA_W-1:0]});
    chk("stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (e_valid && !ordy && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      if (f) mq.delete();
      else begin
        if (e_valid && ordy) void'(mq.pop_front());
        if (iv && e_ready) mq.push_back({wd, wr, wdata});
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_wd = 5'd3; in_wreg = 1'b1; in_wdata = 32'hDEAD;
    @(posedge clk); #1;

    // Reset held with in_valid asserted
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 32'h55);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stall", {60'd0, stall_cnt}, 64'd0);

    // Streaming 1..8, then drain
    for (int n = 1; n <= 8; n++) step(1'b0, 1'b0, 1'b1, 1'b1, 5'(n), 1'b1, 32'h100 + 32'(n));
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0);
    chk("stream_empty", {63'd0, out_valid}, 64'd0);

    // Backpressure: load one, stall 5 cycles while offering more
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 32'hA9);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1'b1, 1'b0, 5'(10 + n), 1'b1, 32'hB0 + 32'(n));
    chk("bp_stall5", {60'd0, stall_cnt}, 64'd5);
    chk("bp_wd_held", {59'd0, out_wd}, 64'd9);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);

    // Flush with stage full and in_valid high
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd20, 1'b1, 32'hF0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0);
    chk("flush_empty", {63'd0, out_valid}, 64'd0);
    chk("flush_keeps_cnt", {60'd0, stall_cnt}, 64'd6);

    // Saturation: 20 stalled cycles
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 32'h11);
    for (int n = 0; n < 20; n++) step(1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 32'h22);
    chk("sat_15", {60'd0, stall_cnt}, 64'd15);

    // Mid-operation reset with stage full and stalled
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 32'h33);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_cnt", {60'd0, stall_cnt}, 64'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
           1'($urandom), ($urandom_range(0, 3) != 0),
           5'($urandom), 1'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
